// File: rtl/id_ex_pkg.sv
// ID/EX pipeline shared definitions: control bundle field layout,
// operand/destination select encodings and small helpers.
package id_ex_pkg;

  localparam int CTRL_BITS  = 10;

  localparam int C_IMM_SIGN = 0;
  localparam int C_SRC_A    = 1;
  localparam int C_SRC_B    = 3;
  localparam int C_REG_DST  = 4;
  localparam int C_RF_WE    = 6;
  localparam int C_MEM_READ = 7;
  localparam int C_JR       = 8;
  localparam int C_USES_RT  = 9;

  localparam int REG31      = 31;

  typedef enum logic [1:0] {
    SRC_A_RS   = 2'd0,
    SRC_A_IMM  = 2'd1,
    SRC_A_PC   = 2'd2,
    SRC_A_ZERO = 2'd3
  } src_a_e;

  typedef enum logic {
    SRC_B_RT  = 1'b0,
    SRC_B_IMM = 1'b1
  } src_b_e;

  typedef enum logic [1:0] {
    DST_RT   = 2'd0,
    DST_RD   = 2'd1,
    DST_R31  = 2'd2,
    DST_NONE = 2'd3
  } reg_dst_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/id_ex_regfile.sv
// Two-read one-write register file, register 0 hardwired to zero,
// same-cycle write visible on the read ports.
module id_ex_regfile
  import id_ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rdata_a = regs_q[raddr_a];
    if (raddr_a == '0) begin
      rdata_a = '0;
    end else if (we && (waddr == raddr_a)) begin
      rdata_a = wdata;
    end
  end

  always_comb begin
    rdata_b = regs_q[raddr_b];
    if (raddr_b == '0) begin
      rdata_b = '0;
    end else if (we && (waddr == raddr_b)) begin
      rdata_b = wdata;
    end
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register with operand read, hazard stall and flush.
// Define ID_EX_FWD_EN to enable the MEM-stage bypass (load-use stall only).
module id_ex_pipe
  import id_ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       id_inst,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              mem_fwd_we,
  input  logic [REG_AW-1:0] mem_fwd_waddr,
  input  logic [DATA_W-1:0] mem_fwd_wdata,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_branch_addr,
  output logic [31:0]       ex_jump_addr,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_waddr,
  output logic [CTRL_W-1:0] ex_ctrl
);

  logic [REG_AW-1:0] rs, rt, rd;
  logic [DATA_W-1:0] rf_a, rf_b;
  logic [DATA_W-1:0] rs_data, rt_data;
  logic              rs_used, rt_used;
  logic              ex_hit, stall, load;
  src_a_e            src_a;
  src_b_e            src_b;
  reg_dst_e          reg_dst;

  logic              ex_valid_q, ex_valid_d;
  logic [31:0]       ex_pc_q, ex_pc_d;
  logic [31:0]       ex_br_q, ex_br_d;
  logic [31:0]       ex_jmp_q, ex_jmp_d;
  logic [DATA_W-1:0] ex_op_a_q, ex_op_a_d;
  logic [DATA_W-1:0] ex_op_b_q, ex_op_b_d;
  logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
  logic [REG_AW-1:0] ex_waddr_q, ex_waddr_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;

  logic [DATA_W-1:0] imm;
  logic [31:0]       pc4, off;
  logic              unused_bits;

  assign rs = id_inst[21 +: REG_AW];
  assign rt = id_inst[16 +: REG_AW];
  assign rd = id_inst[11 +: REG_AW];

  assign src_a   = src_a_e'(id_ctrl[C_SRC_A +: 2]);
  assign src_b   = src_b_e'(id_ctrl[C_SRC_B]);
  assign reg_dst = reg_dst_e'(id_ctrl[C_REG_DST +: 2]);

  id_ex_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_we),
    .waddr   (wb_waddr),
    .wdata   (wb_wdata),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

  assign rs_used = (src_a == SRC_A_RS) || id_ctrl[C_JR];
  assign rt_used = id_ctrl[C_USES_RT];

  assign ex_hit = (ex_waddr_q != '0) &&
                  ((rs_used && (ex_waddr_q == rs)) ||
                   (rt_used && (ex_waddr_q == rt)));

`ifdef ID_EX_FWD_EN
  logic fwd_ok;
  assign fwd_ok  = mem_fwd_we && (mem_fwd_waddr != '0);
  assign rs_data = (fwd_ok && (mem_fwd_waddr == rs)) ? mem_fwd_wdata : rf_a;
  assign rt_data = (fwd_ok && (mem_fwd_waddr == rt)) ? mem_fwd_wdata : rf_b;
  assign stall   = ex_valid_q && ex_ctrl_q[C_MEM_READ] && ex_hit;
  assign unused_bits = ^{id_inst[31:26]};
`else
  logic mem_hit;
  assign mem_hit = (mem_fwd_waddr != '0) &&
                   ((rs_used && (mem_fwd_waddr == rs)) ||
                    (rt_used && (mem_fwd_waddr == rt)));
  assign rs_data = rf_a;
  assign rt_data = rf_b;
  assign stall   = (ex_valid_q && ex_ctrl_q[C_RF_WE] && ex_hit) ||
                   (mem_fwd_we && mem_hit);
  assign unused_bits = ^{id_inst[31:26], mem_fwd_wdata};
`endif

  assign id_ready = rst && !flush && (!ex_valid_q || ex_ready) && !stall;
  assign load     = id_valid && id_ready;

  always_comb begin
    pc4 = id_pc + 32'd4;
    off = sext16(id_inst[15:0]);
    imm = id_ctrl[C_IMM_SIGN] ?
          {{(DATA_W-16){id_inst[15]}}, id_inst[15:0]} :
          {{(DATA_W-16){1'b0}}, id_inst[15:0]};
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_pc_d    = ex_pc_q;
    ex_br_d    = ex_br_q;
    ex_jmp_d   = ex_jmp_q;
    ex_op_a_d  = ex_op_a_q;
    ex_op_b_d  = ex_op_b_q;
    ex_imm_d   = ex_imm_q;
    ex_waddr_d = ex_waddr_q;
    ex_ctrl_d  = ex_ctrl_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (load) begin
      ex_valid_d = 1'b1;
      ex_pc_d    = id_pc;
      ex_br_d    = pc4 + (off << 2);
      ex_jmp_d   = id_ctrl[C_JR] ? rs_data[31:0] :
                   {pc4[31:28], id_inst[25:0], 2'b00};
      ex_imm_d   = imm;
      ex_ctrl_d  = id_ctrl;
      unique case (src_a)
        SRC_A_RS:   ex_op_a_d = rs_data;
        SRC_A_IMM:  ex_op_a_d = imm;
        SRC_A_PC:   ex_op_a_d = DATA_W'(id_pc);
        SRC_A_ZERO: ex_op_a_d = '0;
        default:    ex_op_a_d = '0;
      endcase
      ex_op_b_d = (src_b == SRC_B_IMM) ? imm : rt_data;
      unique case (reg_dst)
        DST_RT:   ex_waddr_d = rt;
        DST_RD:   ex_waddr_d = rd;
        DST_R31:  ex_waddr_d = REG_AW'(REG31);
        DST_NONE: ex_waddr_d = '0;
        default:  ex_waddr_d = '0;
      endcase
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_br_q    <= '0;
      ex_jmp_q   <= '0;
      ex_op_a_q  <= '0;
      ex_op_b_q  <= '0;
      ex_imm_q   <= '0;
      ex_waddr_q <= '0;
      ex_ctrl_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_pc_q    <= ex_pc_d;
      ex_br_q    <= ex_br_d;
      ex_jmp_q   <= ex_jmp_d;
      ex_op_a_q  <= ex_op_a_d;
      ex_op_b_q  <= ex_op_b_d;
      ex_imm_q   <= ex_imm_d;
      ex_waddr_q <= ex_waddr_d;
      ex_ctrl_q  <= ex_ctrl_d;
    end
  end

  assign ex_valid       = ex_valid_q;
  assign ex_pc          = ex_pc_q;
  assign ex_branch_addr = ex_br_q;
  assign ex_jump_addr   = ex_jmp_q;
  assign ex_op_a        = ex_op_a_q;
  assign ex_op_b        = ex_op_b_q;
  assign ex_imm         = ex_imm_q;
  assign ex_waddr       = ex_waddr_q;
  assign ex_ctrl        = ex_ctrl_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: directed scenarios then random traffic
// checked against an instruction-level reference model.
module tb_id_ex_pipe;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic [31:0] id_pc = '0;
  logic [31:0] id_inst = '0;
  logic [9:0]  id_ctrl = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic [31:0] wb_wdata = '0;
  logic        mem_fwd_we = 1'b0;
  logic [4:0]  mem_fwd_waddr = '0;
  logic [31:0] mem_fwd_wdata = '0;
  logic        flush = 1'b0;
  logic        ex_valid;
  logic        ex_ready = 1'b0;
  logic [31:0] ex_pc, ex_branch_addr, ex_jump_addr;
  logic [31:0] ex_op_a, ex_op_b, ex_imm;
  logic [4:0]  ex_waddr;
  logic [9:0]  ex_ctrl;

  always #5 clk = ~clk;

  id_ex_pipe dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_inst(id_inst), .id_ctrl(id_ctrl),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .mem_fwd_we(mem_fwd_we), .mem_fwd_waddr(mem_fwd_waddr),
    .mem_fwd_wdata(mem_fwd_wdata), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_branch_addr(ex_branch_addr),
    .ex_jump_addr(ex_jump_addr), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .ex_imm(ex_imm), .ex_waddr(ex_waddr), .ex_ctrl(ex_ctrl)
  );

  typedef struct {
    logic [31:0] pc, br, jmp, a, b, imm;
    logic [4:0]  wa;
    logic [9:0]  ctrl;
  } item_t;

  typedef struct {
    logic        v;
    logic [31:0] pc, inst;
    logic [9:0]  ctrl;
    logic        wbwe;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        mfwe;
    logic [4:0]  mfa;
    logic [31:0] mfd;
    logic        fl, exr, rn;
  } stim_t;

  item_t       q[$];
  logic [31:0] rf [32];
  int          total = 0;
  int          bad = 0;
  bit          started = 0;
  bit          rst_seen = 0;

  function automatic logic [9:0] mk_ctrl(
    input logic sgn, input logic [1:0] sa, input logic sb,
    input logic [1:0] dst, input logic we, input logic mr,
    input logic jr, input logic urt);
    return {urt, jr, mr, we, dst, sb, sa, sgn};
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{v:1'b0, pc:'0, inst:'0, ctrl:'0, wbwe:1'b0, wba:'0, wbd:'0,
          mfwe:1'b0, mfa:'0, mfd:'0, fl:1'b0, exr:1'b1, rn:1'b1};
    return s;
  endfunction

  function automatic logic [31:0] rtype(input int rs, rt, rd);
    logic [4:0] a, b, c;
    a = 5'(rs); b = 5'(rt); c = 5'(rd);
    return {6'd0, a, b, c, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] read_reg(input logic [4:0] a, input stim_t s);
    if (a == 0) return 32'd0;
    if (FWD && s.mfwe && s.mfa == a) return s.mfd;
    if (s.wbwe && s.wba == a) return s.wbd;
    return rf[a];
  endfunction

  function automatic item_t expect_item(input stim_t s);
    item_t       it;
    logic [4:0]  rs, rt, rd;
    logic [15:0] i16;
    logic [25:0] tgt;
    logic [31:0] rsv, rtv;
    rs = s.inst[25:21]; rt = s.inst[20:16]; rd = s.inst[15:11];
    i16 = s.inst[15:0]; tgt = s.inst[25:0];
    rsv = read_reg(rs, s);
    rtv = read_reg(rt, s);
    it.pc   = s.pc;
    it.ctrl = s.ctrl;
    it.imm  = s.ctrl[0] ? 32'($signed(i16)) : 32'(i16);
    case (s.ctrl[2:1])
      2'd0: it.a = rsv;
      2'd1: it.a = it.imm;
      2'd2: it.a = s.pc;
      default: it.a = 32'd0;
    endcase
    it.b = s.ctrl[3] ? it.imm : rtv;
    case (s.ctrl[5:4])
      2'd0: it.wa = rt;
      2'd1: it.wa = rd;
      2'd2: it.wa = 5'd31;
      default: it.wa = 5'd0;
    endcase
    it.br  = s.pc + 32'd4 + 32'($signed(i16)) * 32'd4;
    it.jmp = s.ctrl[8] ? rsv :
             (((s.pc + 32'd4) & 32'hF000_0000) | (32'(tgt) * 32'd4));
    return it;
  endfunction

  function automatic bit depends(input logic [4:0] a, input stim_t s);
    bit rs_used, rt_used;
    rs_used = (s.ctrl[2:1] == 2'd0) || s.ctrl[8];
    rt_used = s.ctrl[9];
    return (a != 0) && ((rs_used && a == s.inst[25:21]) ||
                        (rt_used && a == s.inst[20:16]));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(input stim_t s);
    bit stall, exp_rdy;
    @(negedge clk);
    id_valid = s.v; id_pc = s.pc; id_inst = s.inst; id_ctrl = s.ctrl;
    wb_we = s.wbwe; wb_waddr = s.wba; wb_wdata = s.wbd;
    mem_fwd_we = s.mfwe; mem_fwd_waddr = s.mfa; mem_fwd_wdata = s.mfd;
    flush = s.fl; ex_ready = s.exr; rst = s.rn;
    #1;
    if (FWD)
      stall = q.size() != 0 && q[0].ctrl[7] && depends(q[0].wa, s);
    else
      stall = (q.size() != 0 && q[0].ctrl[6] && depends(q[0].wa, s)) ||
              (s.mfwe && depends(s.mfa, s));
    exp_rdy = s.rn && !s.fl && (q.size() == 0 || s.exr) && !stall;
    if (started) begin
      if (rst_seen) begin
        total++;
        if ({ex_valid, ex_pc, ex_branch_addr, ex_jump_addr, ex_op_a,
             ex_op_b, ex_imm, ex_waddr, ex_ctrl} !== '0) begin
          bad++;
          $display("FAIL reset_zero: got valid=%b pc=%h a=%h b=%h want all 0",
                   ex_valid, ex_pc, ex_op_a, ex_op_b);
        end
      end
      chk("ex_valid", 32'(ex_valid), 32'(q.size() != 0));
      chk("id_ready", 32'(id_ready), 32'(exp_rdy));
    end
    if (!s.rn) begin
      q.delete();
      for (int i = 0; i < 32; i++) rf[i] = '0;
    end else begin
      if (s.v && exp_rdy) q.push_back(expect_item(s));
      if (s.wbwe && s.wba != 0) rf[s.wba] = s.wbd;
    end
    rst_seen = !s.rn;
    started  = 1;
  endtask

  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #4;
      if (rst === 1'b1 && ex_valid === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL sb_empty: got ex_valid=1 pc=%h want no instruction", ex_pc);
        end else begin
          it = q[0];
          if ({ex_pc, ex_branch_addr, ex_jump_addr, ex_op_a, ex_op_b,
               ex_imm, ex_waddr, ex_ctrl} !==
              {it.pc, it.br, it.jmp, it.a, it.b, it.imm, it.wa, it.ctrl}) begin
            bad++;
            $display("FAIL ex_data: got pc=%h br=%h j=%h a=%h b=%h imm=%h wa=%0d c=%h want pc=%h br=%h j=%h a=%h b=%h imm=%h wa=%0d c=%h",
                     ex_pc, ex_branch_addr, ex_jump_addr, ex_op_a, ex_op_b,
                     ex_imm, ex_waddr, ex_ctrl, it.pc, it.br, it.jmp, it.a,
                     it.b, it.imm, it.wa, it.ctrl);
          end
          if (ex_ready || flush) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    stim_t s;
    logic [9:0] c_add, c_lw, c_beq, c_j;
    c_add = mk_ctrl(0, 2'd0, 0, 2'd1, 1, 0, 0, 1);
    c_lw  = mk_ctrl(1, 2'd0, 1, 2'd0, 1, 1, 0, 0);
    c_beq = mk_ctrl(1, 2'd0, 0, 2'd3, 0, 0, 0, 1);
    c_j   = mk_ctrl(0, 2'd3, 0, 2'd3, 0, 0, 0, 0);

    s = idle(); s.rn = 0;
    step(s); step(s);
    step(idle());

    for (int i = 0; i < 4; i++) begin
      s = idle(); s.v = 1; s.pc = 32'(i * 4);
      s.inst = rtype(1, 2, 3); s.ctrl = c_add;
      step(s);
      if (i > 0) chk("b2b_pc", ex_pc, 32'((i - 1) * 4));
    end
    step(idle());
    chk("b2b_pc", ex_pc, 32'h0000_000C);
    step(idle());

    s = idle(); s.v = 1; s.inst = rtype(5, 0, 6); s.ctrl = c_add;
    s.wbwe = 1; s.wba = 5'd5; s.wbd = 32'h1234;
    step(s);
    s = idle(); s.v = 1; s.inst = rtype(0, 0, 7); s.ctrl = c_add;
    s.wbwe = 1; s.wba = 5'd0; s.wbd = 32'hFFFF;
    step(s);
    chk("wb_bypass", ex_op_a, 32'h1234);
    step(idle());
    chk("r0_read", ex_op_a, 32'h0);

    step(idle());
    s = idle(); s.v = 1; s.pc = 32'h20; s.ctrl = c_lw;
    s.inst = {6'h23, 5'd1, 5'd8, 16'd0};
    step(s);
    s = idle(); s.v = 1; s.pc = 32'h24; s.ctrl = c_add;
    s.inst = rtype(8, 8, 9);
    step(s);
    chk("lu_stall", 32'(id_ready), 32'd0);
    s.mfwe = 1; s.mfa = 5'd8; s.mfd = 32'hCAFE;
    step(s);
    s.mfwe = 0; s.wbwe = 1; s.wba = 5'd8; s.wbd = 32'hCAFE;
    step(s);
    step(idle()); step(idle());

    s = idle(); s.v = 1; s.pc = 32'h40; s.inst = rtype(1, 2, 3); s.ctrl = c_add;
    step(s);
    s.pc = 32'h44; s.exr = 0;
    step(s); step(s); step(s);
    chk("hold_pc", ex_pc, 32'h40);
    s.fl = 1;
    step(s);
    step(idle());
    chk("flush_kill", 32'(ex_valid), 32'd0);

    s = idle(); s.v = 1; s.pc = 32'h100; s.ctrl = c_beq;
    s.inst = {6'h04, 5'd0, 5'd0, 16'hFFFF};
    step(s);
    step(idle());
    chk("branch", ex_branch_addr, 32'h100);
    s = idle(); s.v = 1; s.pc = 32'h8000_0000; s.ctrl = c_j;
    s.inst = {6'h02, 26'h10};
    step(s);
    step(idle());
    chk("jump", ex_jump_addr, 32'h8000_0040);

    s = idle(); s.v = 1; s.pc = 32'h60; s.inst = rtype(1, 2, 4); s.ctrl = c_add;
    step(s);
    s.exr = 0; s.pc = 32'h64;
    step(s);
    s.rn = 0;
    step(s);
    step(idle());
    chk("rst_drop", 32'(ex_valid), 32'd0);

    for (int n = 0; n < 400; n++) begin
      s = idle();
      s.v    = ($urandom_range(0, 3) != 0);
      s.pc   = $urandom & 32'hFFFF_FFFC;
      s.inst = $urandom;
      s.inst[25:21] = 5'($urandom_range(0, 7));
      s.inst[20:16] = 5'($urandom_range(0, 7));
      s.inst[15:11] = 5'($urandom_range(0, 7));
      s.ctrl = 10'($urandom);
      s.wbwe = ($urandom_range(0, 2) == 0);
      s.wba  = 5'($urandom_range(0, 7));
      s.wbd  = $urandom;
      s.mfwe = ($urandom_range(0, 3) == 0);
      s.mfa  = 5'($urandom_range(0, 7));
      s.mfd  = $urandom;
      s.fl   = ($urandom_range(0, 9) == 0);
      s.exr  = ($urandom_range(0, 3) != 0);
      s.rn   = ($urandom_range(0, 63) != 0);
      step(s);
    end

    step(idle()); step(idle()); step(idle());
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
